// File: rtl/dut_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dut_fifo                                                      |
// | Purpose  : Single-clock show-ahead FIFO with valid/ready handshakes on   |
// |            both sides. Status outputs come from registered state only.   |
// | Ports    : clk          - clock, state updates on rising edge           |
// |            rst          - asynchronous active-high reset                |
// |            data_in      - write data (DATA_WIDTH)                       |
// |            data_in_vld  - write request                                 |
// |            data_in_rdy  - FIFO can accept a word (not full, out of rst) |
// |            data_out     - head-of-FIFO word, 0 when empty               |
// |            data_out_vld - data_out holds a valid word (not empty)       |
// |            data_out_rdy - consumer accepts data_out                     |
// |            level        - occupancy count (only with DUT_FIFO_LEVEL_EN) |
// | Options  : define DUT_FIFO_LEVEL_EN to add the level output port.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dut_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_vld,
  output logic                  data_in_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_vld,
  input  logic                  data_out_rdy
`ifdef DUT_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  // Held low during reset so data_in_rdy reads 0 while rst is asserted and
  // rises on the first clock edge after release.
  logic          active_q;

  logic full_w;
  logic empty_w;
  logic wr_en_w;
  logic rd_en_w;

  assign full_w  = (count_q == C_FULL_COUNT);
  assign empty_w = (count_q == '0);

  assign data_in_rdy  = active_q && !full_w;
  assign data_out_vld = !empty_w;

  // Write is gated by data_in_rdy, so a read in the same cycle as full never
  // lets a write slip in.
  assign wr_en_w = data_in_vld  && data_in_rdy;
  assign rd_en_w = data_out_vld && data_out_rdy;

  assign data_out = data_out_vld ? mem_q[rd_ptr_q] : '0;

`ifdef DUT_FIFO_LEVEL_EN
  assign level = count_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (wr_en_w) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en_w) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en_w && !rd_en_w) begin
      count_d = count_q + CW'(1);
    end else if (rd_en_w && !wr_en_w) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      active_q <= 1'b1;
    end
  end

  // Storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dut_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dut_fifo                                                   |
// | Purpose  : Directed self-checking bench for dut_fifo (default build).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dut_fifo;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_in_vld;
  logic          data_in_rdy;
  logic [DW-1:0] data_out;
  logic          data_out_vld;
  logic          data_out_rdy;

  int total;
  int bad;

  dut_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_in_vld (data_in_vld),
    .data_in_rdy (data_in_rdy),
    .data_out    (data_out),
    .data_out_vld(data_out_vld),
    .data_out_rdy(data_out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    data_in      = '0;
    data_in_vld  = 1'b0;
    data_out_rdy = 1'b0;

    // Reset before any clock edge: outputs must already be quiet.
    #1;
    check("rst_rdy_async", 32'(data_in_rdy), 32'd0);
    check("rst_vld_async", 32'(data_out_vld), 32'd0);
    tick();
    tick();
    check("rst_rdy", 32'(data_in_rdy), 32'd0);
    check("rst_vld", 32'(data_out_vld), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_rdy", 32'(data_in_rdy), 32'd1);
    check("post_rst_vld", 32'(data_out_vld), 32'd0);

    // Single word with the consumer stalled.
    data_in     = 8'hA5;
    data_in_vld = 1'b1;
    check("one_no_bypass", 32'(data_out_vld), 32'd0);
    tick();
    data_in_vld = 1'b0;
    data_in     = 8'h00;
    check("one_vld", 32'(data_out_vld), 32'd1);
    check("one_dout", 32'(data_out), 32'hA5);
    tick();
    tick();
    check("one_hold_vld", 32'(data_out_vld), 32'd1);
    check("one_hold_dout", 32'(data_out), 32'hA5);
    data_out_rdy = 1'b1;
    tick();
    data_out_rdy = 1'b0;
    check("one_read_vld", 32'(data_out_vld), 32'd0);
    check("one_read_dout", 32'(data_out), 32'd0);

    // Fill to full with 0x00..0x0F.
    for (int i = 0; i < DP; i++) begin
      check("fill_rdy", 32'(data_in_rdy), 32'd1);
      data_in     = 8'(i);
      data_in_vld = 1'b1;
      tick();
    end
    check("full_rdy", 32'(data_in_rdy), 32'd0);
    check("full_head", 32'(data_out), 32'h00);
    // 17th write while full is ignored.
    data_in = 8'hFF;
    tick();
    check("full_ign_rdy", 32'(data_in_rdy), 32'd0);
    check("full_ign_head", 32'(data_out), 32'h00);

    // Full with write and read together: only the read completes.
    data_out_rdy = 1'b1;
    tick();
    data_in_vld = 1'b0;
    check("full_rw_rdy", 32'(data_in_rdy), 32'd1);
    check("full_rw_head", 32'(data_out), 32'h01);
    // Drain the remaining 15 words; the 0xFF must never surface.
    for (int i = 1; i < DP; i++) begin
      check("drain_vld", 32'(data_out_vld), 32'd1);
      check("drain_dout", 32'(data_out), 32'(i));
      tick();
    end
    data_out_rdy = 1'b0;
    check("drain_empty", 32'(data_out_vld), 32'd0);
    check("drain_dout0", 32'(data_out), 32'd0);

    // Streaming 40 words with both sides always ready.
    data_out_rdy = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c < 40) begin
        data_in     = 8'(8'h40 + c);
        data_in_vld = 1'b1;
      end else begin
        data_in_vld = 1'b0;
      end
      if (c == 0) begin
        check("strm_first_vld", 32'(data_out_vld), 32'd0);
      end else begin
        check("strm_vld", 32'(data_out_vld), 32'd1);
        check("strm_dout", 32'(data_out), 32'(8'h40 + c - 1));
        check("strm_rdy", 32'(data_in_rdy), 32'd1);
      end
      tick();
    end
    data_out_rdy = 1'b0;
    check("strm_end_vld", 32'(data_out_vld), 32'd0);

    // Five words stored, then a mid-run reset pulse.
    for (int i = 0; i < 5; i++) begin
      data_in     = 8'(8'h50 + i);
      data_in_vld = 1'b1;
      tick();
    end
    data_in_vld = 1'b0;
    check("mid_pre_vld", 32'(data_out_vld), 32'd1);
    check("mid_pre_dout", 32'(data_out), 32'h50);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(data_out_vld), 32'd0);
    check("mid_rst_rdy", 32'(data_in_rdy), 32'd0);
    check("mid_rst_dout", 32'(data_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rel_rdy", 32'(data_in_rdy), 32'd1);
    check("mid_rel_vld", 32'(data_out_vld), 32'd0);
    // A fresh word must come out first: old contents were discarded.
    data_in     = 8'h77;
    data_in_vld = 1'b1;
    tick();
    data_in_vld = 1'b0;
    check("mid_new_dout", 32'(data_out), 32'h77);
    data_out_rdy = 1'b1;
    tick();
    data_out_rdy = 1'b0;
    check("mid_new_empty", 32'(data_out_vld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dut_fifo.md
DUT_FIFO -- requirements
Module: dut_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of data_in and data_out.
REQ-002 Parameter DEPTH, default 16: number of storage entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH  write data.
REQ-006 data_in_vld  input  1  write request; data_in valid.
REQ-007 data_in_rdy  output  1  FIFO can accept a word this cycle.
REQ-008 data_out  output  DATA_WIDTH  head-of-FIFO data.
REQ-009 data_out_vld  output  1  data_out holds a valid word.
REQ-010 data_out_rdy  input  1  consumer accepts data_out this cycle.

Function
REQ-011 Write handshake: a word SHALL be stored when data_in_vld && data_in_rdy at a clk rising edge.
REQ-012 Read handshake: the head word SHALL be removed when data_out_vld && data_out_rdy at a clk rising edge.
REQ-013 Ordering: strict first-in first-out, with no loss or duplication.
REQ-014 data_in_rdy SHALL equal !full, derived from registered state only, with no combinational path from data_out_rdy.
REQ-015 data_out_vld SHALL equal !empty, derived from registered state only, with no combinational path from data_in_vld.
REQ-016 Show-ahead: while data_out_vld=1, data_out SHALL present the oldest stored word, stable until it is read.
REQ-017 data_out SHALL be driven to 0 whenever data_out_vld=0.
REQ-018 Latency: a word accepted at edge N SHALL be visible on data_out with data_out_vld=1 after edge N, at the earliest; there is no same-cycle bypass.
REQ-019 Occupancy counter: range 0..DEPTH; +1 on write only, -1 on read only, unchanged on simultaneous write+read.
REQ-020 Full (count=DEPTH): data_in_rdy=0 and writes are ignored, even if a read occurs in the same cycle.
REQ-021 Empty (count=0): data_out_vld=0; a write while empty makes the word valid on the next cycle.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH without a gap or stall.
REQ-023 When neither handshake completes, the stored contents and pointers SHALL be held.

Reset
REQ-024 While rst=1: pointers=0, count=0, data_in_rdy=0, data_out_vld=0, data_out=0, effective immediately (asynchronous).
REQ-025 The first clk edge after rst deasserts SHALL present data_in_rdy=1 and data_out_vld=0.
REQ-026 Assertion of rst mid-operation SHALL discard all stored words; storage array contents need not be cleared.

Configuration
REQ-027 Macro DUT_FIFO_LEVEL_EN, when defined, SHALL add output port level (width $clog2(DEPTH)+1) equal to the registered occupancy count, reset to 0.
REQ-028 When DUT_FIFO_LEVEL_EN is undefined, the level port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset check: hold rst=1 -> data_in_rdy=0, data_out_vld=0, data_out=0; release rst -> data_in_rdy=1 on the next edge.
REQ-030 Single word: write 0xA5 with data_out_rdy=0 -> data_out_vld=1 and data_out=0xA5 on the next cycle, held stable; assert data_out_rdy -> data_out_vld=0 one cycle later.
REQ-031 Fill: write 16 words 0x00..0x0F with no reads -> data_in_rdy=0 after the 16th write; a 17th write of 0xFF is ignored; draining returns 0x00..0x0F in order.
REQ-032 Full with simultaneous traffic: when full, assert data_in_vld and data_out_rdy together -> only the read completes, count becomes 15, and data_in_rdy=1 the next cycle.
REQ-033 Streaming: continuous valid and ready for 40 words -> in-order output, throughput of 1 word/cycle after the first, and pointers wrap twice without error.
REQ-034 Mid-run reset: with 5 words stored, pulse rst -> data_out_vld=0 and data_in_rdy=0 immediately, and the FIFO is empty after release.
